// File: rtl/g711_enc_pipe_if.sv
// G.711 encoder stream bundle.
// Carries the linear-sample input stream and the encoded-code output stream,
// each with its own valid/ready handshake.
//   master : sample producer and code consumer (drives in_*, out_ready)
//   slave  : the encoder (drives in_ready, out_valid, out_ch, out_code, out_sat)
interface g711_enc_pipe_if #(
    parameter int unsigned CH_W = 2
) ();
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic            in_law;
    logic [13:0]     in_pcm;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [7:0]      out_code;
    logic            out_sat;

    modport master (
        output in_valid, in_ch, in_law, in_pcm, out_ready,
        input  in_ready, out_valid, out_ch, out_code, out_sat
    );

    modport slave (
        input  in_valid, in_ch, in_law, in_pcm, out_ready,
        output in_ready, out_valid, out_ch, out_code, out_sat
    );
endinterface

// File: rtl/g711_enc_pipe.sv
// Two-stage pipelined G.711 (u-law / A-law) encoder for tagged multi-channel streams.
// S1 captures sign, biased/saturated magnitude, clip and mute per sample;
// S2 does the segment/mantissa encode, applies the inversion mask and drives the output.
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        g711_enc_pipe_if.slave: in_valid/in_ready/in_ch/in_law/in_pcm,
//              out_valid/out_ready/out_ch/out_code/out_sat
//   mute       per-channel mute, sampled with each accepted sample
//   sat_clr    per-channel sticky clip-flag clear
//   sat_flags  sticky per-channel clip indicators
module g711_enc_pipe #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CH_W = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    g711_enc_pipe_if.slave bus,
    input  logic [NCH-1:0] mute,
    input  logic [NCH-1:0] sat_clr,
    output logic [NCH-1:0] sat_flags
);

    // Handshake
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_load;
    logic s1_load;

    assign s2_load      = !out_valid_q || bus.out_ready;
    assign s1_load      = !s1_valid_q || s2_load;
    assign bus.in_ready = s1_load;

    // S1 front end: sign, magnitude, clip, mute
    logic        in_sign;
    logic [13:0] u_mag;
    logic [12:0] u_biased;
    logic        u_sat;
    logic [12:0] a_x;
    logic [12:0] a_abs;
    logic [11:0] a_mag;
    logic        a_sat;
    logic        in_muted;
    logic        in_clip;
    logic [12:0] in_mag;

    always_comb begin
        in_sign = bus.in_pcm[13];

        // u-law takes the one's-complement magnitude of negative samples (G.191 style),
        // so -1 encodes next to idle and -8192 lands on 8191.
        u_mag = in_sign ? ~bus.in_pcm : bus.in_pcm;
        if (u_mag >= 14'd8159) begin
            u_biased = 13'h1FFF;
            u_sat    = (u_mag > 14'd8159);
        end else begin
            u_biased = 13'(u_mag + 14'd33);
            u_sat    = 1'b0;
        end

        // A-law works on in_pcm >>> 1; dropping bit 0 is exactly that shift.
        a_x   = bus.in_pcm[13:1];
        a_abs = a_x[12] ? (13'd0 - a_x) : a_x;
        a_sat = a_abs[12];
        a_mag = a_sat ? 12'hFFF : a_abs[11:0];

        // Tags at or above NCH never match, so they are never muted.
        in_muted = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (bus.in_ch == CH_W'(c)) begin
                in_muted = mute[c];
            end
        end

        in_clip = (bus.in_law ? a_sat : u_sat) && !in_muted;
        in_mag  = bus.in_law ? {1'b0, a_mag} : u_biased;
    end

    // Sticky clip flags: set on the S1 load edge of a clipped unmuted sample, set beats clear.
    logic [NCH-1:0] sat_flags_q;
    logic [NCH-1:0] sat_flags_d;

    always_comb begin
        sat_flags_d = sat_flags_q;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (s1_load && bus.in_valid && in_clip && (bus.in_ch == CH_W'(c))) begin
                sat_flags_d[c] = 1'b1;
            end else if (sat_clr[c]) begin
                sat_flags_d[c] = 1'b0;
            end
        end
    end

    assign sat_flags = sat_flags_q;

    // S1 register
    logic [CH_W-1:0] s1_ch_q;
    logic            s1_law_q;
    logic            s1_sign_q;
    logic [12:0]     s1_mag_q;
    logic            s1_sat_q;
    logic            s1_mute_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_law_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_sat_q    <= 1'b0;
            s1_mute_q   <= 1'b0;
            sat_flags_q <= '0;
        end else begin
            sat_flags_q <= sat_flags_d;
            if (s1_load) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_ch_q   <= bus.in_ch;
                    s1_law_q  <= bus.in_law;
                    s1_sign_q <= in_sign;
                    s1_mag_q  <= in_mag;
                    s1_sat_q  <= in_clip;
                    s1_mute_q <= in_muted;
                end
            end
        end
    end

    // S2 encode: segment from the leading one, mantissa is the next four bits down
    logic [2:0] seg;
    logic [3:0] mant;
    logic [7:0] code_enc;

    always_comb begin
        seg  = 3'd0;
        mant = 4'd0;
        if (s1_law_q) begin
            for (int i = 5; i <= 11; i++) begin
                if (s1_mag_q[i]) begin
                    seg = 3'(i - 4);
                end
            end
            if (seg == 3'd0) begin
                mant = s1_mag_q[4:1];
            end else begin
                mant = 4'(s1_mag_q >> seg);
            end
        end else begin
            // Biased u-law magnitude is always >= 33, so a leading one exists in [12:5].
            for (int i = 5; i <= 12; i++) begin
                if (s1_mag_q[i]) begin
                    seg = 3'(i - 5);
                end
            end
            mant = 4'(s1_mag_q >> ({1'b0, seg} + 4'd1));
        end

        if (s1_mute_q) begin
            code_enc = s1_law_q ? 8'hD5 : 8'hFF;
        end else begin
            code_enc = {s1_sign_q, seg, mant} ^ (s1_law_q ? 8'hD5 : 8'hFF);
        end
    end

    // S2 / output register
    logic [CH_W-1:0] out_ch_q;
    logic [7:0]      out_code_q;
    logic            out_sat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_code_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_ch_q   <= s1_ch_q;
                out_code_q <= code_enc;
                out_sat_q  <= s1_sat_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_code  = out_code_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_g711_enc_pipe.sv
module tb_g711_enc_pipe;
    localparam int unsigned NCH  = 3;
    localparam int unsigned CH_W = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] mute;
    logic [NCH-1:0] sat_clr;
    logic [NCH-1:0] sat_flags;

    g711_enc_pipe_if #(.CH_W(CH_W)) bus ();

    g711_enc_pipe #(.NCH(NCH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .mute      (mute),
        .sat_clr   (sat_clr),
        .sat_flags (sat_flags)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference encoder: returns {sat, code}
    function automatic logic [8:0] model_enc(input logic law, input int ch,
                                             input logic [13:0] pcm, input logic [NCH-1:0] mv);
        int p, sgn, mag, mb, seg, mant;
        logic sat;
        for (int c = 0; c < int'(NCH); c++) begin
            if (c == ch && mv[c]) return law ? 9'h0D5 : 9'h0FF;
        end
        p   = int'($signed(pcm));
        sgn = (p < 0) ? 1 : 0;
        if (!law) begin
            mag = sgn ? (-p - 1) : p;
            sat = (mag > 8159);
            mb  = mag + 33;
            if (mb > 8191) mb = 8191;
            seg = 0;
            while ((mb >> (seg + 6)) != 0) seg++;
            mant = (mb >> (seg + 1)) & 15;
            return {sat, 8'((sgn << 7) | (seg << 4) | mant) ^ 8'hFF};
        end else begin
            mag = p >>> 1;
            if (mag < 0) mag = -mag;
            sat = (mag > 4095);
            if (sat) mag = 4095;
            if (mag < 32) begin
                seg  = 0;
                mant = mag >> 1;
            end else begin
                seg = 1;
                while ((mag >> (seg + 5)) != 0) seg++;
                mant = (mag >> seg) & 15;
            end
            return {sat, 8'((sgn << 7) | (seg << 4) | mant) ^ 8'hD5};
        end
    endfunction

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [7:0]      code;
        logic            sat;
        int              stamp;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        logic       sat;
        int         lat;
        int         popcyc;
    } log_t;

    exp_t           q[$];
    log_t           lg[$];
    logic [NCH-1:0] mflags;
    logic           prev_stall;
    logic [CH_W-1:0] prev_ch;
    logic [7:0]     prev_code;
    logic           prev_sat;
    int             blocked = 0;
    logic           exp_v, exp_r;
    exp_t           e;
    log_t           l;
    logic [8:0]     r;

    // Compare process: DUT against the queue model on every cycle out of reset
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            mflags     = '0;
            prev_stall = 1'b0;
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].stamp + 2);
            exp_r = !(q.size() == 2 && !bus.out_ready);
            chk("in_ready", bus.in_ready, exp_r);
            chk("out_valid", bus.out_valid, exp_v);
            chk("sat_flags", sat_flags, mflags);
            if (prev_stall) begin
                chk("hold_ch", bus.out_ch, prev_ch);
                chk("hold_code", bus.out_code, prev_code);
                chk("hold_sat", bus.out_sat, prev_sat);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_ch    = bus.out_ch;
            prev_code  = bus.out_code;
            prev_sat   = bus.out_sat;
            if (bus.in_valid && !bus.in_ready) blocked++;
            if (exp_v && bus.out_ready) begin
                e = q.pop_front();
                chk("out_ch", bus.out_ch, e.ch);
                chk("out_code", bus.out_code, e.code);
                chk("out_sat", bus.out_sat, e.sat);
                l.code   = bus.out_code;
                l.sat    = bus.out_sat;
                l.lat    = cyc - e.stamp;
                l.popcyc = cyc;
                lg.push_back(l);
            end
            // Model state for the coming edge
            e.ch = 'x;
            e.sat = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                r       = model_enc(bus.in_law, int'(bus.in_ch), bus.in_pcm, mute);
                e.ch    = bus.in_ch;
                e.code  = r[7:0];
                e.sat   = r[8];
                e.stamp = cyc;
                q.push_back(e);
            end
            for (int c = 0; c < int'(NCH); c++) begin
                if (e.sat && e.ch == CH_W'(c)) mflags[c] = 1'b1;
                else if (sat_clr[c])          mflags[c] = 1'b0;
            end
        end
    end

    // Drivers: all called at posedge + 1
    task automatic send(input logic [CH_W-1:0] ch, input logic law, input logic [13:0] pcm);
        int n;
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.in_law   = law;
        bus.in_pcm   = pcm;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", n < 100, 1'b1);
        idle(1);
    endtask

    task automatic clear_flags();
        sat_clr = '1;
        idle(1);
        sat_clr = '0;
    endtask

    logic [13:0] edge_pcm [12] = '{14'd0, 14'd1, 14'd16383, 14'd8191, 14'd8192, 14'd8158,
                                   14'd8159, 14'd8160, 14'd8225, 14'd8224, 14'd8223, 14'd16382};
    logic [7:0]  exp36 [4] = '{8'hFF, 8'h80, 8'h00, 8'h7F};
    logic        sat36 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0]  exp37 [3] = '{8'hD5, 8'hAA, 8'h2A};
    logic        sat37 [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  exp39 [3] = '{8'hFF, 8'h00, 8'hD5};
    logic        sat39 [3] = '{1'b0, 1'b1, 1'b0};
    int          base;
    int          blk0;
    logic        rand_done;

    initial begin
        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.in_law    = 1'b0;
        bus.in_pcm    = '0;
        bus.out_ready = 1'b0;
        mute          = '0;
        sat_clr       = '0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_code", bus.out_code, 8'h00);
        chk("rst_sat_flags", sat_flags, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.out_ready = 1'b1;

        // u-law corner codes, back to back
        base = lg.size();
        send(0, 1'b0, 14'd0);
        send(0, 1'b0, 14'd8191);
        send(0, 1'b0, 14'd8192);
        send(0, 1'b0, 14'd16383);
        drain();
        chk("ulaw_count", lg.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("ulaw_code", lg[base + i].code, exp36[i]);
            chk("ulaw_sat", lg[base + i].sat, sat36[i]);
            chk("ulaw_latency", lg[base + i].lat, 2);
            chk("ulaw_consec", lg[base + i].popcyc - lg[base].popcyc, i);
        end

        // A-law corner codes
        base = lg.size();
        send(0, 1'b1, 14'd0);
        send(0, 1'b1, 14'd8191);
        send(0, 1'b1, 14'd8192);
        drain();
        chk("alaw_count", lg.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("alaw_code", lg[base + i].code, exp37[i]);
            chk("alaw_sat", lg[base + i].sat, sat37[i]);
        end

        // Backpressure mid-stream
        base = lg.size();
        blk0 = blocked;
        fork
            for (int i = 0; i < 8; i++) begin
                send(CH_W'(i % 4), 1'(i % 2), 14'($urandom_range(0, 16383)));
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", lg.size() - base, 8);
        chk("bp_blocked", (blocked - blk0) > 0, 1'b1);

        // Mute channel 2
        clear_flags();
        mute = 3'b100;
        base = lg.size();
        send(2, 1'b0, 14'd8192);
        send(1, 1'b0, 14'd8192);
        send(2, 1'b1, 14'd8192);
        drain();
        chk("mute_count", lg.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("mute_code", lg[base + i].code, exp39[i]);
            chk("mute_sat", lg[base + i].sat, sat39[i]);
        end
        chk("mute_flag2", sat_flags[2], 1'b0);
        chk("mute_flag1", sat_flags[1], 1'b1);
        mute = '0;

        // Set beats clear, then clear alone
        sat_clr = 3'b010;
        send(1, 1'b0, 14'd8191);
        sat_clr = '0;
        chk("setclr_flag1", sat_flags[1], 1'b1);
        sat_clr = 3'b010;
        idle(1);
        sat_clr = '0;
        chk("clr_flag1", sat_flags[1], 1'b0);
        drain();

        // Out-of-range tag: never muted, no flag
        clear_flags();
        mute = '1;
        base = lg.size();
        send(3, 1'b0, 14'd8192);
        drain();
        chk("oor_code", lg[base].code, 8'h00);
        chk("oor_sat", lg[base].sat, 1'b1);
        chk("oor_flags", sat_flags, '0);
        mute = '0;

        // Randomized traffic
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(CH_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? edge_pcm[$urandom_range(0, 11)]
                                                     : 14'($urandom_range(0, 16383)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                    if ($urandom_range(0, 15) == 0) mute = NCH'($urandom);
                    sat_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        sat_clr = '0;
        mute = '0;
        drain();

        // Reset with two samples in flight
        base = lg.size();
        send(0, 1'b0, 14'd8191);
        send(1, 1'b1, 14'd100);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_flag0", sat_flags[0], 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_flags", sat_flags, '0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(6);
        chk("rst_no_stale", lg.size() - base, 0);

        // First edge after release accepts a sample
        base = lg.size();
        send(1, 1'b0, 14'd0);
        drain();
        chk("post_rst_code", lg[base].code, 8'hFF);
        chk("post_rst_lat", lg[base].lat, 2);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

    initial begin
        #1000000;
        nerr++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $fatal(1, "watchdog");
    end

endmodule
